// File: rtl/bcd_display_mux_if.sv
// Display-mux bus: BCD/decimal-point/blanking inputs and the multiplexed LED drive outputs.
// Latency: pure wiring, no state.
// Backpressure: none; the display data is sampled once per frame by the mux.
interface bcd_display_mux_if;
  logic [15:0] digits;
  logic [3:0]  dp_sel;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  modport master (
    output digits, dp_sel, blank_lz,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  digits, dp_sel, blank_lz,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/bcd_display_mux.sv
// Four-digit 7-segment scan mux with per-frame shadowing, leading-zero blanking and anti-ghost window.
// Latency: inputs appear on the display at the next frame boundary; an/seg/dp are combinational from registers.
// Backpressure: none; inputs are sampled only at the frame-end edge and otherwise ignored.
module bcd_display_mux #(
  parameter int DWELL_POWER  = 16,
  parameter int BLANK_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  bcd_display_mux_if.slave bus
);

  localparam logic [DWELL_POWER-1:0] DWELL_MAX = {DWELL_POWER{1'b1}};
  localparam logic [DWELL_POWER-1:0] BLANK_LIM = DWELL_POWER'(BLANK_CYCLES);

  logic [DWELL_POWER-1:0] dwell_q, dwell_d;
  logic [1:0]             idx_q, idx_d;
  logic [15:0]            digits_q, digits_d;
  logic [3:0]             dp_sel_q, dp_sel_d;
  logic                   blank_lz_q, blank_lz_d;
  logic                   frame_tick_q, frame_tick_d;

  logic                   dwell_wrap;
  logic                   frame_end;
  logic [3:0]             cur_digit;
  logic                   cur_blank;
  logic                   blank3, blank2, blank1;

  assign dwell_wrap = (dwell_q == DWELL_MAX);
  assign frame_end  = dwell_wrap && (idx_q == 2'd3);

  // Next-state: free-running dwell/index scan, shadow reload only at the frame boundary.
  always_comb begin
    dwell_d      = dwell_q + 1'b1;
    idx_d        = idx_q;
    digits_d     = digits_q;
    dp_sel_d     = dp_sel_q;
    blank_lz_d   = blank_lz_q;
    frame_tick_d = 1'b0;
    if (dwell_wrap) begin
      idx_d = idx_q + 2'd1;
    end
    if (frame_end) begin
      digits_d     = bus.digits;
      dp_sel_d     = bus.dp_sel;
      blank_lz_d   = bus.blank_lz;
      frame_tick_d = 1'b1;
    end
  end

  // State registers; reset abandons the current frame without loading the shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q      <= '0;
      idx_q        <= '0;
      digits_q     <= '0;
      dp_sel_q     <= '0;
      blank_lz_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      dwell_q      <= dwell_d;
      idx_q        <= idx_d;
      digits_q     <= digits_d;
      dp_sel_q     <= dp_sel_d;
      blank_lz_q   <= blank_lz_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Leading-zero chain: a digit blanks only if every more-significant digit also blanks.
  assign blank3 = blank_lz_q && (digits_q[15:12] == 4'd0);
  assign blank2 = blank3 && (digits_q[11:8] == 4'd0);
  assign blank1 = blank2 && (digits_q[7:4] == 4'd0);

  // Select the shadow digit and its blank flag for the active slot; digit 0 never blanks.
  always_comb begin
    cur_digit = digits_q[3:0];
    cur_blank = 1'b0;
    case (idx_q)
      2'd0: begin cur_digit = digits_q[3:0];   cur_blank = 1'b0;   end
      2'd1: begin cur_digit = digits_q[7:4];   cur_blank = blank1; end
      2'd2: begin cur_digit = digits_q[11:8];  cur_blank = blank2; end
      2'd3: begin cur_digit = digits_q[15:12]; cur_blank = blank3; end
      default: begin cur_digit = digits_q[3:0]; cur_blank = 1'b0; end
    endcase
  end

  // Output drive: anodes dark during the anti-ghost window, active-low segment decode.
  always_comb begin
    bus.an = ~(4'b0001 << idx_q);
    if (dwell_q < BLANK_LIM) begin
      bus.an = 4'b1111;
    end
    case (cur_digit)
      4'd0:    bus.seg = 7'b1000000;
      4'd1:    bus.seg = 7'b1111001;
      4'd2:    bus.seg = 7'b0100100;
      4'd3:    bus.seg = 7'b0110000;
      4'd4:    bus.seg = 7'b0011001;
      4'd5:    bus.seg = 7'b0010010;
      4'd6:    bus.seg = 7'b0000010;
      4'd7:    bus.seg = 7'b1111000;
      4'd8:    bus.seg = 7'b0000000;
      4'd9:    bus.seg = 7'b0010000;
      default: bus.seg = 7'b0111111;
    endcase
    if (cur_blank) begin
      bus.seg = 7'b1111111;
    end
    bus.dp         = ~dp_sel_q[idx_q];
    bus.frame_tick = frame_tick_q;
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux at DWELL_POWER=2, BLANK_CYCLES=1 (16-clock frames).
// Latency: checks sampled on the falling edge, k clocks after an observed frame_tick.
// Backpressure: none; every wait on frame_tick is bounded.
module tb_bcd_display_mux;

  logic clk;
  logic reset;
  bcd_display_mux_if bus_if ();

  bcd_display_mux #(.DWELL_POWER(2), .BLANK_CYCLES(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dps;
    logic        blz;
    int          k;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs [0:39];
  int   nv = 0;

  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge that shows frame_tick; returns clocks taken.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (bus_if.frame_tick !== 1'b1 && cycles < 40);
    if (bus_if.frame_tick !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_tick: no frame_tick within %0d clocks", cycles);
    end
  endtask

  task automatic add(input logic [15:0] d, input logic [3:0] p, input logic b, input int k,
                     input logic [3:0] an, input logic [6:0] seg, input logic dp);
    vecs[nv] = '{d, p, b, k, an, seg, dp};
    nv++;
  endtask

  int cyc;

  initial begin
    reset = 1'b0;
    bus_if.digits   = 16'h0000;
    bus_if.dp_sel   = 4'b0000;
    bus_if.blank_lz = 1'b0;

    // Scan order, anti-ghost window, decimal point.
    add(16'h1234, 4'b0001, 1'b0,  0, 4'b1111, 7'b0011001, 1'b0);
    add(16'h1234, 4'b0001, 1'b0,  1, 4'b1110, 7'b0011001, 1'b0);
    add(16'h1234, 4'b0001, 1'b0,  3, 4'b1110, 7'b0011001, 1'b0);
    add(16'h1234, 4'b0001, 1'b0,  5, 4'b1101, 7'b0110000, 1'b1);
    add(16'h1234, 4'b0001, 1'b0, 10, 4'b1011, 7'b0100100, 1'b1);
    add(16'h1234, 4'b0001, 1'b0, 12, 4'b1111, 7'b1111001, 1'b1);
    add(16'h1234, 4'b0001, 1'b0, 13, 4'b0111, 7'b1111001, 1'b1);
    // Leading-zero blanking.
    add(16'h0070, 4'b0000, 1'b1, 13, 4'b0111, 7'b1111111, 1'b1);
    add(16'h0070, 4'b0000, 1'b1,  9, 4'b1011, 7'b1111111, 1'b1);
    add(16'h0070, 4'b0000, 1'b1,  5, 4'b1101, 7'b1111000, 1'b1);
    add(16'h0070, 4'b0000, 1'b1,  1, 4'b1110, 7'b1000000, 1'b1);
    add(16'h0070, 4'b0000, 1'b0, 13, 4'b0111, 7'b1000000, 1'b1);
    add(16'h0070, 4'b0000, 1'b0,  9, 4'b1011, 7'b1000000, 1'b1);
    add(16'h0000, 4'b1111, 1'b1,  1, 4'b1110, 7'b1000000, 1'b0);
    add(16'h0000, 4'b1111, 1'b1,  5, 4'b1101, 7'b1111111, 1'b0);
    add(16'h0000, 4'b1111, 1'b1, 13, 4'b0111, 7'b1111111, 1'b0);
    add(16'h1004, 4'b0000, 1'b1,  9, 4'b1011, 7'b1000000, 1'b1);
    add(16'h1004, 4'b0000, 1'b1,  5, 4'b1101, 7'b1000000, 1'b1);
    add(16'h0104, 4'b0000, 1'b1, 13, 4'b0111, 7'b1111111, 1'b1);
    add(16'h0104, 4'b0000, 1'b1,  9, 4'b1011, 7'b1111001, 1'b1);
    add(16'h0104, 4'b0000, 1'b1,  5, 4'b1101, 7'b1000000, 1'b1);
    add(16'h0005, 4'b0000, 1'b1,  1, 4'b1110, 7'b0010010, 1'b1);
    // Invalid BCD and remaining decodes.
    add(16'h00A0, 4'b0000, 1'b0,  5, 4'b1101, 7'b0111111, 1'b1);
    add(16'hF00F, 4'b0000, 1'b0,  1, 4'b1110, 7'b0111111, 1'b1);
    add(16'hF00F, 4'b0000, 1'b0, 13, 4'b0111, 7'b0111111, 1'b1);
    add(16'h9876, 4'b0100, 1'b0,  1, 4'b1110, 7'b0000010, 1'b1);
    add(16'h9876, 4'b0100, 1'b0,  5, 4'b1101, 7'b1111000, 1'b1);
    add(16'h9876, 4'b0100, 1'b0,  9, 4'b1011, 7'b0000000, 1'b0);
    add(16'h9876, 4'b0100, 1'b0, 13, 4'b0111, 7'b0010000, 1'b1);

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("reset_an",   32'(bus_if.an),         32'h0F);
    chk("reset_seg",  32'(bus_if.seg),        32'h40);
    chk("reset_dp",   32'(bus_if.dp),         32'h1);
    chk("reset_tick", 32'(bus_if.frame_tick), 32'h0);
    #19 reset = 1'b0;

    // First frame_tick lands 16 clocks after release.
    wait_tick(cyc);
    chk("first_tick_delay", 32'(cyc), 32'd16);

    // Table-driven vectors.
    for (int i = 0; i < nv; i++) begin
      bus_if.digits   = vecs[i].digits;
      bus_if.dp_sel   = vecs[i].dps;
      bus_if.blank_lz = vecs[i].blz;
      wait_tick(cyc);
      repeat (vecs[i].k) @(negedge clk);
      n_vec++;
      if (bus_if.an !== vecs[i].an || bus_if.seg !== vecs[i].seg || bus_if.dp !== vecs[i].dp ||
          bus_if.frame_tick !== (vecs[i].k == 0)) begin
        n_bad++;
        $display("FAIL vec%0d d=%h k=%0d: an=%b seg=%b dp=%b tick=%b expected an=%b seg=%b dp=%b tick=%b",
                 i, vecs[i].digits, vecs[i].k, bus_if.an, bus_if.seg, bus_if.dp, bus_if.frame_tick,
                 vecs[i].an, vecs[i].seg, vecs[i].dp, (vecs[i].k == 0));
      end
    end

    // Frame period.
    wait_tick(cyc);
    wait_tick(cyc);
    chk("tick_period", 32'(cyc), 32'd16);

    // Tear-free update: change inputs during the digit-1 slot.
    bus_if.digits   = 16'h1111;
    bus_if.dp_sel   = 4'b0000;
    bus_if.blank_lz = 1'b0;
    wait_tick(cyc);
    repeat (4) @(negedge clk);
    bus_if.digits = 16'h2222;
    @(negedge clk);
    chk("tear_k5_seg", 32'(bus_if.seg), 32'h79);
    repeat (4) @(negedge clk);
    chk("tear_k9_seg", 32'(bus_if.seg), 32'h79);
    repeat (4) @(negedge clk);
    chk("tear_k13_seg", 32'(bus_if.seg), 32'h79);
    wait_tick(cyc);
    chk("tear_tick_delay", 32'(cyc), 32'd3);
    @(negedge clk);
    chk("tear_new_seg", 32'(bus_if.seg), 32'h24);

    // Reset mid-frame at index 2, dwell 2.
    bus_if.digits = 16'h1234;
    bus_if.dp_sel = 4'b0001;
    wait_tick(cyc);
    repeat (10) @(negedge clk);
    chk("mid_idx_pre", 32'(dut.idx_q), 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_idx",    32'(dut.idx_q),         32'd0);
    chk("mid_dwell",  32'(dut.dwell_q),       32'd0);
    chk("mid_shadow", 32'(dut.digits_q),      32'd0);
    chk("mid_an",     32'(bus_if.an),         32'h0F);
    chk("mid_seg",    32'(bus_if.seg),        32'h40);
    chk("mid_dp",     32'(bus_if.dp),         32'h1);
    chk("mid_tick",   32'(bus_if.frame_tick), 32'h0);
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_post_an",  32'(bus_if.an),  32'h0D);
    chk("mid_post_seg", 32'(bus_if.seg), 32'h40);
    chk("mid_post_dp",  32'(bus_if.dp),  32'h1);
    wait_tick(cyc);
    chk("mid_tick_delay", 32'(cyc), 32'd11);
    @(negedge clk);
    chk("mid_reload_seg", 32'(bus_if.seg), 32'h19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 SHALL have parameter DWELL_POWER, default 16: each digit is scanned for 2^DWELL_POWER clocks.
REQ-002 SHALL have parameter BLANK_CYCLES, default 4: anti-ghost window, in clocks, at the start of each digit slot; legal range 0 to 2^DWELL_POWER-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port digits, input, 16 bits: four BCD digits {d3,d2,d1,d0}; d0 is the least significant.
REQ-006 SHALL have port dp_sel, input, 4 bits: per-digit decimal point, active-high; bit i belongs to digit i.
REQ-007 SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking when high.
REQ-008 SHALL have port an, output, 4 bits: active-low digit enables; bit i drives digit i.
REQ-009 SHALL have port seg, output, 7 bits: active-low segments ordered {g,f,e,d,c,b,a}.
REQ-010 SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-011 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at the start of each frame.

Function
REQ-012 SHALL keep a DWELL_POWER-bit dwell counter that increments every clock and wraps from 2^DWELL_POWER-1 to 0.
REQ-013 SHALL keep a 2-bit digit index that advances 0->1->2->3->0 in the cycle the dwell counter wraps; a frame is 4*2^DWELL_POWER clocks.
REQ-014 SHALL load shadow registers from digits, dp_sel and blank_lz on the clock edge where index 3 and dwell 2^DWELL_POWER-1 move to index 0 and dwell 0; the shadow holds all display data.
REQ-015 SHALL NOT change the shadow registers at any other time, so that input changes mid-frame appear only at the next frame.
REQ-016 SHALL register frame_tick and drive it high for exactly one cycle: the cycle where index=0, dwell=0 and a shadow load occurred on that edge.
REQ-017 SHALL drive an=4'b1111 whenever dwell < BLANK_CYCLES; otherwise an[index]=0 and all other an bits=1.
REQ-018 SHALL decode seg from the shadow digit selected by index as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 SHALL decode any shadow digit value 10-15 to a dash, seg=0111111.
REQ-020 SHALL, when shadow blank_lz=1, blank digit 3 if d3=0, digit 2 if d3 and d2 are both 0, and digit 1 if d3, d2 and d1 are all 0; digit 0 SHALL never be blanked.
REQ-021 SHALL drive seg=1111111 for a blanked digit; dp SHALL still follow dp_sel.
REQ-022 SHALL drive dp = ~shadow_dp_sel[index].
REQ-023 SHALL derive an, seg and dp combinationally from registered state only (index, dwell, shadow); there SHALL be no combinational path from digits, dp_sel or blank_lz to any output.

Reset
REQ-024 SHALL, on reset assertion and independent of clk, clear dwell to 0, index to 0, frame_tick to 0, and all shadow registers to 0.
REQ-025 SHALL hold an=1111 (dwell 0 is inside the blank window when BLANK_CYCLES>0), seg=1000000 and dp=1 while reset is asserted.
REQ-026 SHALL resume counting on the first clock edge after reset release.
REQ-027 SHALL NOT pulse frame_tick until the first full frame after reset has completed.
REQ-028 SHALL, if reset is asserted mid-frame, abandon the frame immediately and perform no shadow load.

Verification (DWELL_POWER=2, BLANK_CYCLES=1, so 4 clocks per digit and 16 clocks per frame)
REQ-029 SHALL cover reset: assert reset asynchronously -> an=1111, seg=1000000, dp=1, frame_tick=0 before any clock edge.
REQ-030 SHALL cover scan order: digits=16'h1234, dp_sel=0001, blank_lz=0; after the first frame_tick, observe:
- digit-0 slot, dwell 1-3: an=1110, seg=0011001, dp=0
- digit-3 slot: an=0111, seg=1111001, dp=1
- frame_tick repeats every 16 clocks.
REQ-031 SHALL cover leading-zero blanking: digits=16'h0070, blank_lz=1 -> digits 3 and 2 seg=1111111, digit 1 seg=1111000, digit 0 seg=1000000; with blank_lz=0, digits 3 and 2 show seg=1000000.
REQ-032 SHALL cover tear-free update: change digits from 16'h1111 to 16'h2222 while index=1 -> the remaining slots still show 1111001, and 0100100 appears only after the next frame_tick.
REQ-033 SHALL cover invalid BCD: digits=16'h00A0 -> digit 1 seg=0111111.
REQ-034 SHALL cover reset mid-frame: pulse reset at index=2, dwell=2 -> index=0, dwell=0, an=1111, shadow cleared, and the next frame_tick arrives 16 clocks after release.
